// File: rtl/fb_pixel_writer.sv
// Framebuffer pixel writer: FIFO-buffered pixel requests and screen clears onto one MIG write port.
// Define FB_PIXEL_COALESCE_EN to merge consecutive same-word pixels into a single masked write.
module fb_pixel_writer #(
    parameter logic [13:0] ADDR_PREFIX = 14'h0000,
    parameter int unsigned SCREEN_W    = 256,
    parameter int unsigned SCREEN_H    = 192,
    parameter int unsigned FIFO_DEPTH  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        calib_done,
    input  logic        clear_req,
    input  logic [7:0]  clear_rgb,
    output logic        clear_busy,
    input  logic        pixel_valid,
    output logic        pixel_ready,
    input  logic [7:0]  pixel_rgb,
    input  logic [7:0]  pixel_x,
    input  logic [7:0]  pixel_y,
    output logic [7:0]  oob_count,
    output logic        mem_cmd_en,
    output logic [2:0]  mem_cmd_instr,
    output logic [5:0]  mem_cmd_bl,
    output logic [29:0] mem_cmd_byte_addr,
    input  logic        mem_cmd_full,
    output logic        mem_wr_en,
    output logic [3:0]  mem_wr_mask,
    output logic [31:0] mem_wr_data,
    input  logic        mem_wr_full,
    input  logic        mem_wr_empty
);

    localparam int unsigned AW        = $clog2(FIFO_DEPTH);
    localparam logic [5:0]  LAST_WORD = 6'(SCREEN_W / 4 - 1);
    localparam logic [7:0]  LAST_LINE = 8'(SCREEN_H - 1);
    localparam logic [8:0]  W_LIM     = 9'(SCREEN_W);
    localparam logic [8:0]  H_LIM     = 9'(SCREEN_H);

    typedef enum logic [2:0] {
        WAIT_CAL, CLR_FILL, CLR_CMD, CLR_WAIT, RUN, PX_WR, PX_CMD
    } state_t;

    state_t state, state_n;

    logic [23:0] fifo_mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        fifo_empty, fifo_full, push, pop;
    logic [7:0]  head_rgb, head_x, head_y;
    logic [13:0] head_word;
    logic [3:0]  head_sel;
    logic        head_oob;

    logic [5:0]  word_cnt;
    logic [7:0]  line;
    logic        clr_pending, clr_start, oob_hit, load_stg;
    logic [7:0]  clr_rgb_q, clr_active;
    logic [13:0] stg_word;
    logic [3:0]  stg_mask;
    logic [31:0] stg_data;

    assign fifo_empty  = (wr_ptr == rd_ptr);
    assign fifo_full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push        = pixel_valid && !fifo_full;
    assign pixel_ready = !fifo_full;

    assign {head_rgb, head_x, head_y} = fifo_mem[rd_ptr[AW-1:0]];
    assign head_word = {head_y, head_x[7:2]};
    assign head_sel  = 4'b0001 << head_x[1:0];
    assign head_oob  = ({1'b0, head_x} >= W_LIM) || ({1'b0, head_y} >= H_LIM);

    assign clear_busy    = clr_pending || (state == CLR_FILL) || (state == CLR_CMD) || (state == CLR_WAIT);
    assign mem_cmd_instr = 3'b000;

`ifdef FB_PIXEL_COALESCE_EN
    logic        stg_merge;
    logic [31:0] head_lanes;
    assign head_lanes = {{8{head_sel[3]}}, {8{head_sel[2]}}, {8{head_sel[1]}}, {8{head_sel[0]}}};
`endif

    always_comb begin
        state_n           = state;
        pop               = 1'b0;
        clr_start         = 1'b0;
        oob_hit           = 1'b0;
        load_stg          = 1'b0;
        mem_cmd_en        = 1'b0;
        mem_cmd_bl        = '0;
        mem_cmd_byte_addr = '0;
        mem_wr_en         = 1'b0;
        mem_wr_mask       = '0;
        mem_wr_data       = '0;
`ifdef FB_PIXEL_COALESCE_EN
        stg_merge         = 1'b0;
`endif
        case (state)
            WAIT_CAL: begin
                if (calib_done) begin
                    state_n   = CLR_FILL;
                    clr_start = 1'b1;
                end
            end
            CLR_FILL: begin
                mem_wr_data = {4{clr_active}};
                if (!mem_wr_full) begin
                    mem_wr_en = 1'b1;
                    if (word_cnt == LAST_WORD)
                        state_n = CLR_CMD;
                end
            end
            CLR_CMD: begin
                mem_cmd_bl        = LAST_WORD;
                mem_cmd_byte_addr = {ADDR_PREFIX, line, 8'h00};
                if (!mem_cmd_full) begin
                    mem_cmd_en = 1'b1;
                    state_n    = CLR_WAIT;
                end
            end
            CLR_WAIT: begin
                if (mem_wr_empty)
                    state_n = (line == LAST_LINE) ? RUN : CLR_FILL;
            end
            RUN: begin
                if (clr_pending && fifo_empty) begin
                    state_n   = CLR_FILL;
                    clr_start = 1'b1;
                end else if (!fifo_empty) begin
                    pop = 1'b1;
                    if (head_oob) begin
                        oob_hit = 1'b1;
                    end else begin
                        load_stg = 1'b1;
                        state_n  = PX_WR;
                    end
                end
            end
            PX_WR: begin
                mem_wr_mask = stg_mask;
                mem_wr_data = stg_data;
`ifdef FB_PIXEL_COALESCE_EN
                // Absorbing a pixel takes priority over the flush, even while memory is full.
                if (!fifo_empty && !head_oob && head_word == stg_word && !clr_pending) begin
                    pop       = 1'b1;
                    stg_merge = 1'b1;
                end else if (!mem_wr_full) begin
                    mem_wr_en = 1'b1;
                    state_n   = PX_CMD;
                end
`else
                if (!mem_wr_full) begin
                    mem_wr_en = 1'b1;
                    state_n   = PX_CMD;
                end
`endif
            end
            PX_CMD: begin
                mem_cmd_byte_addr = {ADDR_PREFIX, stg_word, 2'b00};
                if (!mem_cmd_full) begin
                    mem_cmd_en = 1'b1;
                    state_n    = RUN;
                end
            end
            default: state_n = WAIT_CAL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr[AW-1:0]] <= {pixel_rgb, pixel_x, pixel_y};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= WAIT_CAL;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            word_cnt    <= '0;
            line        <= '0;
            clr_pending <= 1'b1;
            clr_rgb_q   <= '0;
            clr_active  <= '0;
            oob_count   <= '0;
            stg_word    <= '0;
            stg_mask    <= '0;
            stg_data    <= '0;
        end else begin
            state <= state_n;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;

            // A request coinciding with a clear start keeps pending set, re-arming another clear.
            if (clear_req) begin
                clr_pending <= 1'b1;
                clr_rgb_q   <= clear_rgb;
            end else if (clr_start) begin
                clr_pending <= 1'b0;
            end
            if (clr_start) begin
                clr_active <= clr_rgb_q;
                line       <= '0;
            end else if (state == CLR_WAIT && mem_wr_empty) begin
                line <= (line == LAST_LINE) ? 8'd0 : line + 8'd1;
            end

            if (state == CLR_FILL && mem_wr_en)
                word_cnt <= (word_cnt == LAST_WORD) ? 6'd0 : word_cnt + 6'd1;

            if (oob_hit && oob_count != 8'hFF)
                oob_count <= oob_count + 8'd1;

            if (load_stg) begin
                stg_word <= head_word;
                stg_mask <= ~head_sel;
                stg_data <= {4{head_rgb}};
            end
`ifdef FB_PIXEL_COALESCE_EN
            if (stg_merge) begin
                stg_mask <= stg_mask & ~head_sel;
                stg_data <= (stg_data & ~head_lanes) | ({4{head_rgb}} & head_lanes);
            end
`endif
        end
    end

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Directed self-checking bench for fb_pixel_writer with a simple MIG port model.
// Expected results follow FB_PIXEL_COALESCE_EN when it is defined for the build.
module tb_fb_pixel_writer;

    localparam logic [13:0] P = 14'h2A5;

    logic        clk = 1'b0;
    logic        rst, calib_done, clear_req, pixel_valid;
    logic [7:0]  clear_rgb, pixel_rgb, pixel_x, pixel_y;
    logic        clear_busy, pixel_ready;
    logic [7:0]  oob_count;
    logic        mem_cmd_en, mem_cmd_full, mem_wr_en, mem_wr_full, mem_wr_empty;
    logic [2:0]  mem_cmd_instr;
    logic [5:0]  mem_cmd_bl;
    logic [29:0] mem_cmd_byte_addr;
    logic [3:0]  mem_wr_mask;
    logic [31:0] mem_wr_data;

    int n_checks = 0;
    int n_fail   = 0;
    int wsc      = 0;
    logic [35:0] wr_q  [$];
    logic [35:0] cmd_q [$];

    always #5 clk = ~clk;
    assign mem_wr_empty = (wsc == 0);

    fb_pixel_writer #(
        .ADDR_PREFIX(P),
        .SCREEN_W(256),
        .SCREEN_H(192),
        .FIFO_DEPTH(8)
    ) dut (
        .clk(clk), .rst(rst), .calib_done(calib_done),
        .clear_req(clear_req), .clear_rgb(clear_rgb), .clear_busy(clear_busy),
        .pixel_valid(pixel_valid), .pixel_ready(pixel_ready), .pixel_rgb(pixel_rgb),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .oob_count(oob_count),
        .mem_cmd_en(mem_cmd_en), .mem_cmd_instr(mem_cmd_instr), .mem_cmd_bl(mem_cmd_bl),
        .mem_cmd_byte_addr(mem_cmd_byte_addr), .mem_cmd_full(mem_cmd_full),
        .mem_wr_en(mem_wr_en), .mem_wr_mask(mem_wr_mask), .mem_wr_data(mem_wr_data),
        .mem_wr_full(mem_wr_full), .mem_wr_empty(mem_wr_empty)
    );

    // Memory port model: logs traffic and checks strobe/full and write-before-command ordering.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_wr_en) begin
                n_checks++;
                if (mem_wr_full !== 1'b0) begin
                    n_fail++;
                    $display("FAIL wr_while_full: mem_wr_en=1 mem_wr_full=%b required 0", mem_wr_full);
                end
                wr_q.push_back({mem_wr_mask, mem_wr_data});
                wsc++;
            end
            if (mem_cmd_en) begin
                n_checks++;
                if (mem_cmd_full !== 1'b0 || mem_wr_en !== 1'b0 || wsc != int'(mem_cmd_bl) + 1 ||
                    mem_cmd_instr !== 3'b000) begin
                    n_fail++;
                    $display("FAIL cmd_order: full=%b wr_en=%b words=%0d bl=%0d instr=%b required full=0 wr_en=0 words=bl+1 instr=000",
                             mem_cmd_full, mem_wr_en, wsc, mem_cmd_bl, mem_cmd_instr);
                end
                cmd_q.push_back({mem_cmd_bl, mem_cmd_byte_addr});
                wsc = 0;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    task automatic push_px(input logic [7:0] x, input logic [7:0] y, input logic [7:0] rgb);
        int c = 0;
        bit acc = 1'b0;
        pixel_x = x; pixel_y = y; pixel_rgb = rgb; pixel_valid = 1'b1;
        while (!acc && c < 100) begin
            @(negedge clk);
            acc = pixel_ready;
            @(posedge clk); #1;
            c++;
        end
        pixel_valid = 1'b0;
        n_checks++;
        if (!acc) begin
            n_fail++;
            $display("FAIL push_accept: x=%0d y=%0d not accepted in 100 cycles", x, y);
        end
    endtask

    task automatic wait_cmds(input int n, input int limit, output bit ok);
        int c = 0;
        while (cmd_q.size() < n && c < limit) begin
            @(posedge clk); #1;
            c++;
        end
        ok = (cmd_q.size() >= n);
    endtask

    task automatic test_reset;
        rst = 1'b1; calib_done = 1'b0; clear_req = 1'b0; clear_rgb = '0;
        pixel_valid = 1'b0; pixel_rgb = '0; pixel_x = '0; pixel_y = '0;
        mem_cmd_full = 1'b0; mem_wr_full = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({clear_busy, pixel_ready} !== 2'b11) begin
            n_fail++; $display("FAIL reset_flags: busy,ready=%b required 11", {clear_busy, pixel_ready});
        end
        n_checks++;
        if (oob_count !== 8'd0) begin
            n_fail++; $display("FAIL reset_oob: got %0d required 0", oob_count);
        end
        n_checks++;
        if ({mem_cmd_en, mem_wr_en} !== 2'b00) begin
            n_fail++; $display("FAIL reset_strobes: cmd,wr=%b required 00", {mem_cmd_en, mem_wr_en});
        end
        n_checks++;
        if ({mem_cmd_bl, mem_cmd_byte_addr, mem_wr_mask, mem_wr_data, mem_cmd_instr} !== '0) begin
            n_fail++; $display("FAIL reset_buses: bl=%h addr=%h mask=%b data=%h required all 0",
                               mem_cmd_bl, mem_cmd_byte_addr, mem_wr_mask, mem_wr_data);
        end
        rst = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        n_checks++;
        if (wr_q.size() != 0 || cmd_q.size() != 0) begin
            n_fail++; $display("FAIL precal_traffic: wr=%0d cmd=%0d required 0 0", wr_q.size(), cmd_q.size());
        end
        calib_done = 1'b1;
    endtask

    task automatic test_clear(input logic [7:0] col, input int skip);
        int c = 0;
        int bad = 0;
        logic [35:0] e;
        while (clear_busy && c < 20000) begin
            @(posedge clk); #1;
            c++;
        end
        n_checks++;
        if (clear_busy !== 1'b0) begin
            n_fail++; $display("FAIL clear_done: clear_busy=%b required 0", clear_busy);
        end
        n_checks++;
        if (cmd_q.size() != skip + 192) begin
            n_fail++; $display("FAIL clear_bursts: got %0d cmds required %0d", cmd_q.size(), skip + 192);
        end
        for (int i = 0; i < 192 && skip + i < cmd_q.size(); i++) begin
            e = cmd_q[skip + i];
            if (e !== {6'd63, P, 8'(i), 8'h00}) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++; $display("FAIL clear_addr: %0d bursts with wrong bl/addr, required 0", bad);
        end
        bad = 0;
        for (int i = skip; i < wr_q.size(); i++) begin
            e = wr_q[i];
            if (e !== {4'b0000, {4{col}}}) bad++;
        end
        n_checks++;
        if (wr_q.size() != skip + 192 * 64 || bad != 0) begin
            n_fail++; $display("FAIL clear_data: words=%0d bad=%0d required %0d words 0 bad",
                               wr_q.size(), bad, skip + 192 * 64);
        end
    endtask

    task automatic test_single_pixel;
        bit ok;
        wr_q.delete(); cmd_q.delete();
        mem_cmd_full = 1'b1;
        push_px(8'd50, 8'd50, 8'hFF);
        repeat (6) @(posedge clk);
        #1;
        n_checks++;
        if (wr_q.size() != 1 || cmd_q.size() != 0) begin
            n_fail++; $display("FAIL cmd_hold: wr=%0d cmd=%0d required 1 0", wr_q.size(), cmd_q.size());
        end
        mem_cmd_full = 1'b0;
        wait_cmds(1, 20, ok);
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL px_timeout: no command issued");
        end else begin
            n_checks++;
            if (wr_q[0] !== {4'b1011, 32'hFFFFFFFF}) begin
                n_fail++; $display("FAIL px_wr: got %h required %h", wr_q[0], {4'b1011, 32'hFFFFFFFF});
            end
            n_checks++;
            if (cmd_q[0] !== {6'd0, P, 8'h32, 8'h30}) begin
                n_fail++; $display("FAIL px_cmd: got %h required %h", cmd_q[0], {6'd0, P, 8'h32, 8'h30});
            end
        end
    endtask

    task automatic test_oob;
        bit ok;
        wr_q.delete(); cmd_q.delete();
        push_px(8'd200, 8'd195, 8'hAA);
        repeat (10) @(posedge clk);
        #1;
        n_checks++;
        if (oob_count !== 8'd1 || wr_q.size() != 0 || cmd_q.size() != 0) begin
            n_fail++; $display("FAIL oob_first: oob=%0d wr=%0d cmd=%0d required 1 0 0",
                               oob_count, wr_q.size(), cmd_q.size());
        end
        push_px(8'd255, 8'd192, 8'hAA);
        push_px(8'd255, 8'd191, 8'h5A);
        wait_cmds(1, 20, ok);
        n_checks++;
        if (oob_count !== 8'd2 || !ok) begin
            n_fail++; $display("FAIL oob_edge: oob=%0d cmds=%0d required 2 1", oob_count, cmd_q.size());
        end else begin
            n_checks++;
            if (wr_q[0] !== {4'b0111, 32'h5A5A5A5A} || cmd_q[0] !== {6'd0, P, 8'hBF, 8'hFC}) begin
                n_fail++; $display("FAIL last_pixel: wr=%h cmd=%h required %h %h", wr_q[0], cmd_q[0],
                                   {4'b0111, 32'h5A5A5A5A}, {6'd0, P, 8'hBF, 8'hFC});
            end
        end
        for (int i = 0; i < 252; i++) push_px(8'(i), 8'd192 + 8'(i % 64), 8'h11);
        repeat (12) @(posedge clk);
        #1;
        n_checks++;
        if (oob_count !== 8'd254) begin
            n_fail++; $display("FAIL oob_254: got %0d required 254", oob_count);
        end
        for (int i = 0; i < 46; i++) push_px(8'd3, 8'd250, 8'h22);
        repeat (12) @(posedge clk);
        #1;
        n_checks++;
        if (oob_count !== 8'd255 || wr_q.size() != 1) begin
            n_fail++; $display("FAIL oob_saturate: oob=%0d wr=%0d required 255 1", oob_count, wr_q.size());
        end
    endtask

    task automatic test_backpressure;
        int acc_n = 0;
        bit acc;
        bit ok;
        logic [7:0] x, y, rgb;
        wr_q.delete(); cmd_q.delete();
        mem_wr_full = 1'b1;
        pixel_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            pixel_x = 8'(acc_n * 8); pixel_y = 8'(acc_n + 1); pixel_rgb = 8'h10 + 8'(acc_n);
            @(negedge clk);
            acc = pixel_ready;
            @(posedge clk); #1;
            if (acc) acc_n++;
        end
        pixel_valid = 1'b0;
        n_checks++;
        if (acc_n != 9 || pixel_ready !== 1'b0) begin
            n_fail++; $display("FAIL bp_accept: accepted=%0d ready=%b required 9 0", acc_n, pixel_ready);
        end
        n_checks++;
        if (wr_q.size() != 0) begin
            n_fail++; $display("FAIL bp_hold: %0d writes while full, required 0", wr_q.size());
        end
        mem_wr_full = 1'b0;
        wait_cmds(9, 100, ok);
        n_checks++;
        if (!ok || wr_q.size() != 9) begin
            n_fail++; $display("FAIL bp_drain: cmds=%0d wr=%0d required 9 9", cmd_q.size(), wr_q.size());
        end else begin
            for (int i = 0; i < 9; i++) begin
                x = 8'(i * 8); y = 8'(i + 1); rgb = 8'h10 + 8'(i);
                n_checks++;
                if (wr_q[i] !== {4'b1110, {4{rgb}}} || cmd_q[i] !== {6'd0, P, y, x}) begin
                    n_fail++; $display("FAIL bp_order[%0d]: wr=%h cmd=%h required %h %h", i, wr_q[i], cmd_q[i],
                                       {4'b1110, {4{rgb}}}, {6'd0, P, y, x});
                end
            end
        end
    endtask

    task automatic test_clear_with_queue;
        logic [7:0] x;
        wr_q.delete(); cmd_q.delete();
        mem_wr_full = 1'b1;
        for (int i = 0; i < 3; i++) push_px(8'(4 * i + 1), 8'(100 + i), 8'h70 + 8'(i));
        clear_req = 1'b1; clear_rgb = 8'h33;
        @(posedge clk); #1;
        clear_rgb = 8'hE0;
        @(posedge clk); #1;
        clear_req = 1'b0; clear_rgb = 8'h00;
        n_checks++;
        if (clear_busy !== 1'b1) begin
            n_fail++; $display("FAIL clr_pending: clear_busy=%b required 1", clear_busy);
        end
        mem_wr_full = 1'b0;
        test_clear(8'hE0, 3);
        for (int i = 0; i < 3 && i < cmd_q.size() && i < wr_q.size(); i++) begin
            x = 8'(4 * i);
            n_checks++;
            if (wr_q[i] !== {4'b1101, {4{8'h70 + 8'(i)}}} || cmd_q[i] !== {6'd0, P, 8'(100 + i), x}) begin
                n_fail++; $display("FAIL clr_px_first[%0d]: wr=%h cmd=%h required %h %h", i, wr_q[i], cmd_q[i],
                                   {4'b1101, {4{8'h70 + 8'(i)}}}, {6'd0, P, 8'(100 + i), x});
            end
        end
    endtask

    task automatic test_coalesce;
        bit ok;
        wr_q.delete(); cmd_q.delete();
        mem_wr_full = 1'b1;
        for (int i = 0; i < 4; i++) push_px(8'(8 + i), 8'd0, 8'(i + 1));
        mem_wr_full = 1'b0;
`ifdef FB_PIXEL_COALESCE_EN
        wait_cmds(1, 50, ok);
        repeat (10) @(posedge clk);
        #1;
        n_checks++;
        if (!ok || wr_q.size() != 1 || cmd_q.size() != 1) begin
            n_fail++; $display("FAIL coal_count: wr=%0d cmd=%0d required 1 1", wr_q.size(), cmd_q.size());
        end else begin
            n_checks++;
            if (wr_q[0] !== {4'b0000, 32'h04030201} || cmd_q[0] !== {6'd0, P, 8'h00, 8'h08}) begin
                n_fail++; $display("FAIL coal_word: wr=%h cmd=%h required %h %h", wr_q[0], cmd_q[0],
                                   {4'b0000, 32'h04030201}, {6'd0, P, 8'h00, 8'h08});
            end
        end
`else
        wait_cmds(4, 50, ok);
        n_checks++;
        if (!ok || wr_q.size() != 4) begin
            n_fail++; $display("FAIL px_count: wr=%0d cmd=%0d required 4 4", wr_q.size(), cmd_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (wr_q[i] !== {~(4'b0001 << i), {4{8'(i + 1)}}} || cmd_q[i] !== {6'd0, P, 8'h00, 8'h08}) begin
                    n_fail++; $display("FAIL px_lane[%0d]: wr=%h cmd=%h required %h %h", i, wr_q[i], cmd_q[i],
                                       {~(4'b0001 << i), {4{8'(i + 1)}}}, {6'd0, P, 8'h00, 8'h08});
                end
            end
        end
`endif
    endtask

    task automatic test_reset_abort;
        push_px(8'd1, 8'd200, 8'h00);
        pixel_x = 8'd5; pixel_y = 8'd5; pixel_rgb = 8'h99; pixel_valid = 1'b1;
        @(posedge clk); #1;
        pixel_valid = 1'b0;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({mem_cmd_en, mem_wr_en, pixel_ready, clear_busy} !== 4'b0011 || oob_count !== 8'd0) begin
            n_fail++; $display("FAIL async_reset: cmd,wr,ready,busy=%b oob=%0d required 0011 0",
                               {mem_cmd_en, mem_wr_en, pixel_ready, clear_busy}, oob_count);
        end
    endtask

    initial begin
        test_reset;
        test_clear(8'h00, 0);
        test_single_pixel;
        test_oob;
        test_backpressure;
        test_clear_with_queue;
        test_coalesce;
        test_reset_abort;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
